axi4_rd_arbiter: RTL and testbench

//  Two-master round-robin arbiter for the AXI4 read path (AR + R channels) of one AXI4 slave.

---
 rtl/axi4_rd_arbiter.sv | 154 +++++++++++++++
 tb/tb_axi4_rd_arbiter.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_rd_arbiter.sv
// Two-master round-robin arbiter for the AXI4 AR/R read path of one slave.
// A watchdog turns a stalled slave into a DECERR beat for the granted master.
module axi4_rd_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 3,
    parameter int TIMEOUT = 15
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_aresetn,
    input  logic [1:0]          m_arvalid,
    output logic [1:0]          m_arready,
    input  logic [2*ADDR_W-1:0] m_araddr,
    input  logic [15:0]         m_arlen,
    output logic [1:0]          m_rvalid,
    input  logic [1:0]          m_rready,
    output logic [DATA_W-1:0]   m_rdata,
    output logic [1:0]          m_rresp,
    output logic                m_rlast,
    output logic                s_axi_arvalid,
    input  logic                s_axi_arready,
    output logic [ADDR_W-1:0]   s_axi_araddr,
    output logic [7:0]          s_axi_arlen,
    output logic [2:0]          s_axi_arsize,
    output logic [1:0]          s_axi_arburst,
    output logic [ID_W-1:0]     s_axi_arid,
    input  logic                s_axi_rvalid,
    output logic                s_axi_rready,
    input  logic [DATA_W-1:0]   s_axi_rdata,
    input  logic [1:0]          s_axi_rresp,
    input  logic                s_axi_rlast
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ABORT} state_e;

    localparam logic [3:0] TMO = 4'(TIMEOUT);

    state_e              state_q;
    logic                grant_q;
    logic                last_q;
    logic [3:0]          timer_q;
    logic                arvalid_q;
    logic [ADDR_W-1:0]   araddr_q;
    logic [7:0]          arlen_q;
    logic [ID_W-1:0]     arid_q;

    logic req;
    logic pick;
    logic r_hs;
    logic expired;

    assign req     = |m_arvalid;
    assign pick    = (&m_arvalid) ? ~last_q : m_arvalid[1];
    assign r_hs    = s_axi_rvalid & s_axi_rready;
    assign expired = (timer_q == TMO);

    assign s_axi_arvalid = arvalid_q;
    assign s_axi_araddr  = araddr_q;
    assign s_axi_arlen   = arlen_q;
    assign s_axi_arid    = arid_q;
    assign s_axi_arsize  = 3'b010;
    assign s_axi_arburst = 2'b01;

    // Gating arready with reset keeps a master from seeing a grant the reset discards.
    always_comb begin
        m_arready    = '0;
        m_rvalid     = '0;
        s_axi_rready = 1'b0;
        m_rdata      = '0;
        m_rresp      = '0;
        m_rlast      = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_axi_aresetn && req) m_arready[pick] = 1'b1;
            end
            DATA: begin
                m_rvalid[grant_q] = s_axi_rvalid;
                s_axi_rready      = m_rready[grant_q];
                m_rdata           = s_axi_rdata;
                m_rresp           = s_axi_rresp;
                m_rlast           = s_axi_rlast;
            end
            ABORT: begin
                m_rvalid[grant_q] = 1'b1;
                m_rresp           = 2'b11;
                m_rlast           = 1'b1;
                s_axi_rready      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            timer_q   <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arid_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        grant_q   <= pick;
                        arvalid_q <= 1'b1;
                        timer_q   <= '0;
                        araddr_q  <= pick ? m_araddr[ADDR_W +: ADDR_W]
                                          : m_araddr[0 +: ADDR_W];
                        arlen_q   <= pick ? m_arlen[15:8] : m_arlen[7:0];
                        arid_q    <= ID_W'(pick);
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_axi_arready) begin
                        arvalid_q <= 1'b0;
                        timer_q   <= '0;
                        state_q   <= DATA;
                    end else if (expired) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ABORT;
                    end else begin
                        timer_q <= timer_q + 4'd1;
                    end
                end
                DATA: begin
                    // A final beat on the expiry cycle still completes normally.
                    if (r_hs) begin
                        timer_q <= '0;
                        if (s_axi_rlast) begin
                            last_q  <= grant_q;
                            state_q <= IDLE;
                        end
                    end else if (expired) begin
                        state_q <= ABORT;
                    end else begin
                        timer_q <= timer_q + 4'd1;
                    end
                end
                ABORT: begin
                    if (m_rready[grant_q]) begin
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Scoreboard bench for axi4_rd_arbiter: random masters and slave,
// expectations from a grant/burst-level reference model.
module tb_axi4_rd_arbiter;

    localparam int AW  = 24;
    localparam int DW  = 32;
    localparam int IW  = 3;
    localparam int TMO = 15;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    l;
        logic [IW-1:0] id;
    } ar_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          arv0, arv1, rr0, rr1;
    logic [AW-1:0] ad0, ad1;
    logic [7:0]    ln0, ln1;

    logic [1:0]      m_arvalid, m_arready, m_rvalid, m_rready;
    logic [2*AW-1:0] m_araddr;
    logic [15:0]     m_arlen;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic            s_axi_arvalid, s_axi_rready;
    logic [AW-1:0]   s_axi_araddr;
    logic [7:0]      s_axi_arlen;
    logic [2:0]      s_axi_arsize;
    logic [1:0]      s_axi_arburst;
    logic [IW-1:0]   s_axi_arid;
    logic            s_arready, s_rvalid, s_rlast;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;

    assign m_arvalid = {arv1, arv0};
    assign m_rready  = {rr1, rr0};
    assign m_araddr  = {ad1, ad0};
    assign m_arlen   = {ln1, ln0};

    axi4_rd_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .TIMEOUT(TMO)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rstn),
        .m_arvalid     (m_arvalid),
        .m_arready     (m_arready),
        .m_araddr      (m_araddr),
        .m_arlen       (m_arlen),
        .m_rvalid      (m_rvalid),
        .m_rready      (m_rready),
        .m_rdata       (m_rdata),
        .m_rresp       (m_rresp),
        .m_rlast       (m_rlast),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arid    (s_axi_arid),
        .s_axi_rvalid  (s_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_rdata),
        .s_axi_rresp   (s_rresp),
        .s_axi_rlast   (s_rlast)
    );

    int checks = 0;
    int errors = 0;

    bit stall_ar   = 1'b0;
    bit slave_rand = 1'b1;
    bit rand_rr    = 1'b1;
    bit stall0     = 1'b0;

    // Reference model state
    bit    busy  = 1'b0;
    bit    mlast = 1'b1;
    bit    mg    = 1'b0;
    bit    lat_pend = 1'b0;
    ar_t   exp_ar[$];
    beat_t exp_r0[$];
    beat_t exp_r1[$];
    int    grants[$];
    int    beats[2];

    function automatic void chk(input string name,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a,
                                                input int k);
        return {8'(k), a} ^ 32'h0055_AA00;
    endfunction

    function automatic void check_grants(input string name, input int n,
                                         input int e0, input int e1,
                                         input int e2);
        int e[3];
        e = '{e0, e1, e2};
        chk({name, "_count"}, grants.size(), n);
        for (int k = 0; k < n && k < grants.size(); k++)
            chk({name, "_order"}, grants[k], e[k]);
    endfunction

    // Slave model: random or eager AR acceptance, in-order bursts
    initial begin
        ar_t sq[$];
        ar_t cap;
        int  sbeat;
        bit  arh, rh, rst_seen;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        s_rdata   = '0;
        s_rresp   = '0;
        sbeat     = 0;
        forever begin
            @(negedge clk);
            rst_seen = !rstn;
            arh = s_axi_arvalid && s_arready;
            rh  = s_rvalid && s_axi_rready;
            cap = {s_axi_araddr, s_axi_arlen, s_axi_arid};
            @(posedge clk);
            #1;
            if (rst_seen) begin
                sq.delete();
                sbeat = 0;
                s_rvalid = 1'b0;
                s_arready = 1'b0;
                continue;
            end
            if (arh) sq.push_back(cap);
            if (rh && sq.size() > 0) begin
                if (sbeat == int'(sq[0].l)) begin
                    void'(sq.pop_front());
                    sbeat = 0;
                end else begin
                    sbeat++;
                end
            end
            s_arready = stall_ar ? 1'b0 :
                        (slave_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
            if (s_rvalid && !rh) begin
                s_rvalid = 1'b1;
            end else if (sq.size() > 0 &&
                         (!slave_rand || $urandom_range(0, 3) != 0)) begin
                s_rvalid = 1'b1;
                s_rdata  = beat_data(sq[0].a, sbeat);
                s_rlast  = (sbeat == int'(sq[0].l));
                s_rresp  = 2'b00;
            end else begin
                s_rvalid = 1'b0;
            end
        end
    end

    // Master R-ready driver
    initial begin
        rr0 = 1'b1;
        rr1 = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            rr0 = stall0 ? 1'b0 :
                  (rand_rr ? ($urandom_range(0, 3) != 0) : 1'b1);
            rr1 = rand_rr ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [1:0] exp_rdy;
        bit         w;
        ar_t        ea;
        beats[0] = 0;
        beats[1] = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                exp_ar.delete();
                exp_r0.delete();
                exp_r1.delete();
                busy = 1'b0;
                mlast = 1'b1;
                lat_pend = 1'b0;
                continue;
            end
            if (lat_pend) begin
                chk("ar_latency", s_axi_arvalid, 1);
                lat_pend = 1'b0;
            end
            if (!busy) begin
                chk("idle_quiet", {m_rvalid, s_axi_arvalid}, 0);
                if (|m_arvalid) begin
                    w = (&m_arvalid) ? !mlast : m_arvalid[1];
                    exp_rdy = 2'b00;
                    exp_rdy[w] = 1'b1;
                    chk("arready_grant", m_arready, exp_rdy);
                    busy = 1'b1;
                    mg = w;
                    lat_pend = 1'b1;
                    grants.push_back(int'(w));
                    ea.a  = w ? ad1 : ad0;
                    ea.l  = w ? ln1 : ln0;
                    ea.id = IW'(w);
                    if (stall_ar) begin
                        if (w) exp_r1.push_back({32'h0, 2'b11, 1'b1});
                        else   exp_r0.push_back({32'h0, 2'b11, 1'b1});
                    end else begin
                        exp_ar.push_back(ea);
                        for (int k = 0; k <= int'(ea.l); k++) begin
                            if (w) exp_r1.push_back({beat_data(ea.a, k), 2'b00,
                                                     k == int'(ea.l)});
                            else   exp_r0.push_back({beat_data(ea.a, k), 2'b00,
                                                     k == int'(ea.l)});
                        end
                    end
                end
            end else begin
                chk("other_rvalid_low", m_rvalid[!mg], 0);
                chk("arready_while_busy", m_arready, 0);
            end
            for (int i = 0; i < 2; i++) begin
                if (m_rvalid[i] && m_rready[i]) begin
                    beat_t e;
                    bit    have;
                    have = (i == 0) ? (exp_r0.size() > 0) : (exp_r1.size() > 0);
                    chk("r_beat_expected", have, 1);
                    if (have) begin
                        if (i == 0) e = exp_r0.pop_front();
                        else        e = exp_r1.pop_front();
                        chk("rdata", m_rdata, e.d);
                        chk("rresp", m_rresp, e.resp);
                        chk("rlast", m_rlast, e.last);
                        if (e.last) begin
                            busy = 1'b0;
                            mlast = (i == 1);
                        end
                    end
                    beats[i]++;
                end
            end
            if (s_axi_arvalid && s_arready) begin
                chk("ar_expected", exp_ar.size() > 0, 1);
                if (exp_ar.size() > 0) begin
                    ea = exp_ar.pop_front();
                    chk("araddr", s_axi_araddr, ea.a);
                    chk("arlen", s_axi_arlen, ea.l);
                    chk("arid", s_axi_arid, ea.id);
                    chk("arsize_burst", {s_axi_arsize, s_axi_arburst}, 5'b010_01);
                end
            end
        end
    end

    task automatic issue(input int i, input logic [AW-1:0] a,
                         input logic [7:0] l);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        if (i == 0) begin arv0 = 1'b1; ad0 = a; ln0 = l; end
        else        begin arv1 = 1'b1; ad1 = a; ln1 = l; end
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            if (rstn && m_arvalid[i] && m_arready[i]) done = 1'b1;
        end
        @(posedge clk);
        #1;
        if (i == 0) arv0 = 1'b0;
        else        arv1 = 1'b0;
        chk("ar_granted_in_time", done, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_r0.size() != 0 || exp_r1.size() != 0 ||
                arv0 || arv1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", n < 1000, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic wait_beat0(input int target);
        int n;
        n = 0;
        while (beats[0] < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("beat_in_time", beats[0] >= target, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int cnt;
        int n;
        int b;
        logic [DW-1:0] hold;
        arv0 = 1'b0; arv1 = 1'b0;
        ad0 = '0; ad1 = '0; ln0 = '0; ln1 = '0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        @(negedge clk);
        chk("rst_arvalid", s_axi_arvalid, 0);
        chk("rst_araddr", s_axi_araddr, 0);
        chk("rst_arlen", s_axi_arlen, 0);
        chk("rst_arid", s_axi_arid, 0);
        chk("rst_rvalid", m_rvalid, 0);
        chk("rst_rready", s_axi_rready, 0);

        // Single-beat read from master 0
        @(posedge clk);
        #1;
        grants.delete();
        issue(0, 24'h000004, 8'd0);
        wait_idle();
        check_grants("t1", 1, 0, 0, 0);

        // Both request after reset: master 0 then master 1
        pulse_reset();
        grants.delete();
        fork
            issue(0, 24'h001000, 8'd3);
            issue(1, 24'h002000, 8'd1);
        join
        wait_idle();
        check_grants("t2", 2, 0, 1, 0);

        // Master 0 back-to-back against a waiting master 1
        grants.delete();
        fork
            begin
                issue(0, 24'h003000, 8'd2);
                issue(0, 24'h003100, 8'd1);
            end
            issue(1, 24'h004000, 8'd2);
        join
        wait_idle();
        check_grants("t3", 3, 0, 1, 0);

        // Slave never accepts AR: watchdog abort
        rand_rr = 1'b0;
        slave_rand = 1'b0;
        stall_ar = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 24'h00ABC0, 8'd5);
        cnt = 0;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            if (m_rvalid[0]) break;
            if (s_axi_arvalid) cnt++;
            n++;
        end
        chk("t4_abort_seen", m_rvalid[0], 1);
        chk("t4_arvalid_dropped", s_axi_arvalid, 0);
        chk("t4_abort_after_timeout", (cnt >= TMO && cnt <= TMO + 1), 1);
        chk("t4_decerr", {m_rresp, m_rlast}, 3'b111);
        wait_idle();
        stall_ar = 1'b0;

        // Master stalls R mid-burst
        b = beats[0];
        issue(0, 24'h005000, 8'd3);
        wait_beat0(b + 1);
        @(posedge clk);
        #1 stall0 = 1'b1;
        @(negedge clk);
        hold = m_rdata;
        repeat (5) begin
            chk("t5_s_rready_low", s_axi_rready, 0);
            chk("t5_rvalid_held", m_rvalid[0], 1);
            chk("t5_data_held", m_rdata, hold);
            @(negedge clk);
        end
        @(posedge clk);
        #1 stall0 = 1'b0;
        wait_idle();

        // Reset in the middle of a 4-beat burst
        b = beats[0];
        issue(0, 24'h006000, 8'd3);
        wait_beat0(b + 1);
        @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("t6_rvalid", m_rvalid, 0);
        chk("t6_arvalid", s_axi_arvalid, 0);
        chk("t6_s_rready", s_axi_rready, 0);
        chk("t6_araddr", s_axi_araddr, 0);
        chk("t6_arlen", s_axi_arlen, 0);
        @(posedge clk);
        #1;
        grants.delete();
        fork
            issue(1, 24'h007000, 8'd1);
            issue(0, 24'h008000, 8'd2);
        join
        wait_idle();
        check_grants("t6", 2, 0, 1, 0);

        // Randomized traffic from both masters
        rand_rr = 1'b1;
        slave_rand = 1'b1;
        fork
            for (int k = 0; k < 12; k++) begin
                issue(0, AW'($urandom), 8'($urandom_range(0, 7)));
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            for (int k = 0; k < 12; k++) begin
                issue(1, AW'($urandom), 8'($urandom_range(0, 7)));
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
        join
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
